conv_coef_ctrl: RTL and testbench

- Frame-synchronous coefficient loader and scheduler for the 5x5 FIR/convolution stages of the grayscale/Sobel pipeline.
- Accepts a serial stream of 16-bit coefficient words from the host side (fir_coef_write / fir_coef_data) into a shadow bank.
- Commits the shadow bank to the active bank only on a vertical-sync rising edge, so kernels never change mid-frame.
- Drives the flat active-coefficient bus consumed by the convolution instances.

---
 rtl/conv_coef_pkg.sv | 18 +
 rtl/vs_edge_det.sv | 27 ++
 rtl/conv_coef_ctrl.sv | 154 +++++++++++++++
 tb/tb_conv_coef_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_coef_pkg.sv
// Shared types and defaults for the 5x5 convolution coefficient controller.
package conv_coef_pkg;

  // Load/commit sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int COEF_NUM_DEF   = 25;
  localparam int COEF_WIDTH_DEF = 16;
  localparam int COEF_FRAC_DEF  = 8;

  // Centre tap of the 5x5 kernel; carries 1.0 in the identity kernel.
  localparam int CENTRE_IDX = 12;

endpackage

// File: rtl/vs_edge_det.sv
// Vertical-sync polarity normaliser and rising-edge pulse generator.
// POL = 1 passes vs_i through; POL = 0 inverts it, so the active edge of the
// raw input becomes a rising edge of the normalised signal.
module vs_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_i,
  output logic vs_rise
);

  logic vs_n;
  logic vs_d;

  assign vs_n = POL ? vs_i : ~vs_i;

  // Delay the normalised sync by one clock for edge detection.
  // NOTE: registers are assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) vs_d <= 1'b0;
    else     vs_d <= vs_n;
  end

  assign vs_rise = vs_n & ~vs_d;

endmodule

// File: rtl/conv_coef_ctrl.sv
// Frame-synchronous 5x5 coefficient loader: host words fill a shadow bank,
// which is copied to the active bank only on a vertical-sync rising edge.
// Optional macro COEF_CHECKSUM_EN: a 26th word (sum of the 25 taps, truncated)
// must match before the shadow bank is armed; a mismatch raises err_o.
module conv_coef_ctrl
  import conv_coef_pkg::*;
#(
  parameter int COEF_NUM   = COEF_NUM_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int COEF_FRAC  = COEF_FRAC_DEF,
  parameter bit POL_VS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vs_i,
  input  logic                           coef_start_i,
  input  logic                           coef_write_i,
  input  logic [COEF_WIDTH-1:0]          coef_data_i,
  output logic [COEF_NUM*COEF_WIDTH-1:0] coef_o,
  output logic                           busy_o,
  output logic                           armed_o,
  output logic                           commit_o,
  output logic                           err_o
);

  localparam int IDX_W = $clog2(COEF_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COEF_NUM - 1);
  localparam logic [COEF_WIDTH-1:0] IDENT_ONE = COEF_WIDTH'(1) << COEF_FRAC;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [COEF_WIDTH-1:0]   shadow [COEF_NUM];
  logic [COEF_WIDTH-1:0]   active [COEF_NUM];
  logic                    vs_rise;

  vs_edge_det #(
    .POL (POL_VS)
  ) u_vs_edge_det (
    .clk     (clk),
    .rst     (rst),
    .vs_i    (vs_i),
    .vs_rise (vs_rise)
  );

`ifdef COEF_CHECKSUM_EN
  logic                  cks_pend;
  logic [COEF_WIDTH-1:0] shadow_sum;

  // Running two's-complement sum of the shadow taps, truncated to COEF_WIDTH.
  always_comb begin
    shadow_sum = '0;
    for (int k = 0; k < COEF_NUM; k++) shadow_sum = shadow_sum + shadow[k];
  end
`endif

  // Sequencer: shadow loading, arming, frame-boundary commit and error flag.
  always_ff @(posedge clk) begin
    commit_o <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy_o  <= 1'b0;
      armed_o <= 1'b0;
      err_o   <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      cks_pend <= 1'b0;
`endif
      // NOTE: both banks are reset on purpose so the identity kernel is live
      // from the first frame; this makes them flops, not RAM.
      for (int k = 0; k < COEF_NUM; k++) begin
        shadow[k] <= (k == CENTRE_IDX) ? IDENT_ONE : '0;
        active[k] <= (k == CENTRE_IDX) ? IDENT_ONE : '0;
      end
    end else if (coef_start_i) begin
      state   <= IDLE;
      idx     <= '0;
      busy_o  <= 1'b0;
      armed_o <= 1'b0;
      err_o   <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      cks_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (coef_write_i) begin
            shadow[0] <= coef_data_i;
            idx       <= IDX_W'(1);
            state     <= LOAD;
            busy_o    <= 1'b1;
          end
        end
        LOAD: begin
          if (coef_write_i) begin
`ifdef COEF_CHECKSUM_EN
            if (cks_pend) begin
              cks_pend <= 1'b0;
              if (coef_data_i == shadow_sum) begin
                state   <= ARMED;
                armed_o <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
                err_o  <= 1'b1;
              end
            end else begin
              shadow[idx] <= coef_data_i;
              if (idx == LAST_IDX) begin
                idx      <= '0;
                cks_pend <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
`else
            shadow[idx] <= coef_data_i;
            if (idx == LAST_IDX) begin
              idx     <= '0;
              state   <= ARMED;
              armed_o <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
`endif
          end
        end
        ARMED: begin
          if (coef_write_i) err_o <= 1'b1;
          if (vs_rise) begin
            for (int k = 0; k < COEF_NUM; k++) active[k] <= shadow[k];
            commit_o <= 1'b1;
            state    <= IDLE;
            busy_o   <= 1'b0;
            armed_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          idx     <= '0;
          busy_o  <= 1'b0;
          armed_o <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the active bank onto the output bus, tap k at [k*W +: W].
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    coef_o = '0;
    for (int k = 0; k < COEF_NUM; k++) coef_o[k*COEF_WIDTH +: COEF_WIDTH] = active[k];
  end

endmodule

// File: tb/tb_conv_coef_ctrl.sv
// Directed self-checking bench for conv_coef_ctrl. A second instance with
// POL_VS = 0 shares the host-side inputs and has its own sync line.
module tb_conv_coef_ctrl;

  localparam int CN = 25;
  localparam int CW = 16;
  localparam int BW = CN * CW;

  logic          clk;
  logic          rst;
  logic          vs;
  logic          vs_n_raw;
  logic          coef_start;
  logic          coef_write;
  logic [CW-1:0] coef_data;

  logic [BW-1:0] coef, coef_n;
  logic          busy, armed, commit, err;
  logic          busy_n, armed_n, commit_n, err_n;

  int total = 0;
  int bad   = 0;

  conv_coef_ctrl #(.POL_VS(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .vs_i         (vs),
    .coef_start_i (coef_start),
    .coef_write_i (coef_write),
    .coef_data_i  (coef_data),
    .coef_o       (coef),
    .busy_o       (busy),
    .armed_o      (armed),
    .commit_o     (commit),
    .err_o        (err)
  );

  conv_coef_ctrl #(.POL_VS(1'b0)) dut_n (
    .clk          (clk),
    .rst          (rst),
    .vs_i         (vs_n_raw),
    .coef_start_i (coef_start),
    .coef_write_i (coef_write),
    .coef_data_i  (coef_data),
    .coef_o       (coef_n),
    .busy_o       (busy_n),
    .armed_o      (armed_n),
    .commit_o     (commit_n),
    .err_o        (err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] ident();
    logic [BW-1:0] v;
    v = '0;
    v[12*CW +: CW] = 16'h0100;
    return v;
  endfunction

  function automatic logic [BW-1:0] ramp(input logic [CW-1:0] base, input logic [CW-1:0] step);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < CN; k++) v[k*CW +: CW] = base + step * CW'(k);
    return v;
  endfunction

  task automatic set_vs(input logic v);
    vs = v;
    tick();
  endtask

  task automatic pulse_start();
    coef_start = 1'b1;
    tick();
    coef_start = 1'b0;
  endtask

  task automatic write_word(input logic [CW-1:0] d);
    coef_data  = d;
    coef_write = 1'b1;
    tick();
    coef_write = 1'b0;
  endtask

  // Full load of taps base+k; the final word may coincide with a sync edge.
  task automatic load_full(input logic [CW-1:0] base, input bit coincide);
`ifdef COEF_CHECKSUM_EN
    logic [CW-1:0] sum;
    sum = '0;
    for (int k = 0; k < CN; k++) sum = sum + base + CW'(k);
`endif
    for (int k = 0; k < CN - 1; k++) write_word(base + CW'(k));
    total++;
    if (armed !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_mid busy/armed got=%b%b exp=10", busy, armed);
    end
`ifdef COEF_CHECKSUM_EN
    write_word(base + CW'(CN - 1));
    if (coincide) vs = 1'b1;
    write_word(sum);
`else
    if (coincide) vs = 1'b1;
    write_word(base + CW'(CN - 1));
`endif
    total++;
    if (armed !== 1'b1 || busy !== 1'b1 || commit !== 1'b0) begin
      bad++;
      $display("FAIL load_done busy/armed/commit got=%b%b%b exp=110", busy, armed, commit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (coef !== ident()) begin
      bad++;
      $display("FAIL reset_coef got=%h exp=%h", coef, ident());
    end
    total++;
    if (coef_n !== ident()) begin
      bad++;
      $display("FAIL reset_coef_n got=%h exp=%h", coef_n, ident());
    end
    total++;
    if ({busy, armed, commit, err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, armed, commit, err});
    end
    set_vs(1'b1);
    total++;
    if (commit !== 1'b0 || coef !== ident()) begin
      bad++;
      $display("FAIL reset_vs_no_commit commit=%b coef=%h exp commit=0", commit, coef);
    end
    set_vs(1'b0);
  endtask

  task automatic test_abort();
    for (int k = 0; k < 10; k++) write_word(16'h0100 + CW'(k));
    set_vs(1'b1);
    total++;
    if (commit !== 1'b0 || coef !== ident()) begin
      bad++;
      $display("FAIL abort_vs_in_load commit=%b coef=%h exp commit=0 identity", commit, coef);
    end
    set_vs(1'b0);
    pulse_start();
    total++;
    if ({busy, armed, err} !== 3'b000) begin
      bad++;
      $display("FAIL abort_flags got=%b exp=000", {busy, armed, err});
    end
    tick();
    total++;
    if (commit !== 1'b0 || coef !== ident()) begin
      bad++;
      $display("FAIL abort_no_commit commit=%b coef=%h exp commit=0 identity", commit, coef);
    end
  endtask

  task automatic test_full_load();
    load_full(16'd1, 1'b0);
    set_vs(1'b1);
    total++;
    if (commit !== 1'b1) begin
      bad++;
      $display("FAIL full_commit got=%b exp=1", commit);
    end
    total++;
    if (coef !== ramp(16'd1, 16'd1)) begin
      bad++;
      $display("FAIL full_coef got=%h exp=%h", coef, ramp(16'd1, 16'd1));
    end
    total++;
    if ({busy, armed} !== 2'b00) begin
      bad++;
      $display("FAIL full_idle got=%b exp=00", {busy, armed});
    end
    set_vs(1'b0);
    total++;
    if (commit !== 1'b0) begin
      bad++;
      $display("FAIL full_commit_pulse got=%b exp=0", commit);
    end
  endtask

  task automatic test_armed_write();
    load_full(16'h0200, 1'b0);
    write_word(16'h7777);
    total++;
    if (err !== 1'b1 || armed !== 1'b1) begin
      bad++;
      $display("FAIL armed_write err/armed got=%b%b exp=11", err, armed);
    end
    set_vs(1'b1);
    total++;
    if (commit !== 1'b1 || coef !== ramp(16'h0200, 16'd1)) begin
      bad++;
      $display("FAIL armed_write_commit commit=%b coef=%h exp=%h", commit, coef, ramp(16'h0200, 16'd1));
    end
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    set_vs(1'b0);
    pulse_start();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b exp=0", err);
    end
  endtask

  task automatic test_coincide();
    load_full(16'h0300, 1'b1);
    set_vs(1'b0);
    total++;
    if (commit !== 1'b0 || coef !== ramp(16'h0200, 16'd1)) begin
      bad++;
      $display("FAIL coincide_no_commit commit=%b coef=%h exp=%h", commit, coef, ramp(16'h0200, 16'd1));
    end
    set_vs(1'b1);
    total++;
    if (commit !== 1'b1 || coef !== ramp(16'h0300, 16'd1)) begin
      bad++;
      $display("FAIL coincide_next_commit commit=%b coef=%h exp=%h", commit, coef, ramp(16'h0300, 16'd1));
    end
    set_vs(1'b0);
  endtask

  task automatic test_polarity();
    pulse_start();
    load_full(16'h0400, 1'b0);
    total++;
    if (armed_n !== 1'b1 || commit_n !== 1'b0) begin
      bad++;
      $display("FAIL pol_armed armed_n/commit_n got=%b%b exp=10", armed_n, commit_n);
    end
    vs_n_raw = 1'b0;
    tick();
    total++;
    if (commit_n !== 1'b1 || coef_n !== ramp(16'h0400, 16'd1)) begin
      bad++;
      $display("FAIL pol_fall_commit commit_n=%b coef_n=%h exp=%h", commit_n, coef_n, ramp(16'h0400, 16'd1));
    end
    total++;
    if (commit !== 1'b0 || coef !== ramp(16'h0300, 16'd1)) begin
      bad++;
      $display("FAIL pol_other_inst commit=%b coef=%h exp commit=0", commit, coef);
    end
    vs_n_raw = 1'b1;
    tick();
    total++;
    if (commit_n !== 1'b0) begin
      bad++;
      $display("FAIL pol_rise_ignored got=%b exp=0", commit_n);
    end
    pulse_start();
  endtask

`ifdef COEF_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int k = 0; k < CN; k++) write_word(16'h0001);
    write_word(16'h0019);
    total++;
    if (armed !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL cks_good armed/err got=%b%b exp=10", armed, err);
    end
    set_vs(1'b1);
    total++;
    if (commit !== 1'b1 || coef !== ramp(16'h0001, 16'd0)) begin
      bad++;
      $display("FAIL cks_good_commit commit=%b coef=%h", commit, coef);
    end
    set_vs(1'b0);
    pulse_start();
    for (int k = 0; k < CN; k++) write_word(16'h0001);
    write_word(16'h0018);
    total++;
    if ({busy, armed, err} !== 3'b001) begin
      bad++;
      $display("FAIL cks_bad busy/armed/err got=%b exp=001", {busy, armed, err});
    end
    set_vs(1'b1);
    total++;
    if (commit !== 1'b0 || coef !== ramp(16'h0001, 16'd0)) begin
      bad++;
      $display("FAIL cks_bad_no_commit commit=%b coef=%h", commit, coef);
    end
    set_vs(1'b0);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    vs         = 1'b0;
    vs_n_raw   = 1'b1;
    coef_start = 1'b0;
    coef_write = 1'b0;
    coef_data  = '0;
    test_reset();
    test_abort();
    test_full_load();
    test_armed_write();
    test_coincide();
    test_polarity();
`ifdef COEF_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
